relay_tx: RTL

- Transmit side of the relay serial link: serialises bytes from the ARM-side byte stream into framed bit frames on `data_out`.
- Frames use the start/end marker framing that the relay receiver decodes: reader framing in FAKE_READER mode, tag framing in FAKE_TAG mode.
- One bit per 2^DIV_LOG2 clocks; 847.5 kHz at 13.56 MHz with the default.
- Sits between the ARM byte FIFO and the relay link output pin.

---
 rtl/relay_tx.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/relay_tx.sv
// rtl/relay_tx.sv - relay link transmitter: framed MSB-first serialiser behind a one-byte holding register
// Build option: RELAY_TX_PARITY_EN appends an odd-parity bit to every data byte.
module relay_tx #(
  parameter int DIV_LOG2 = 4,
  parameter int GAP_BITS = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] hi_simulate_mod_type,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       data_out,
  output logic       busy,
  output logic       underrun,
  output logic       frame_done
);
  localparam logic [2:0] MODE_READER = 3'b101;
  localparam logic [2:0] MODE_TAG    = 3'b110;
`ifdef RELAY_TX_PARITY_EN
  localparam logic [7:0] BYTE_LAST = 8'd8;
`else
  localparam logic [7:0] BYTE_LAST = 8'd7;
`endif
  localparam logic [7:0] GAP_LAST = 8'(GAP_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_END, S_GAP} state_t;

  state_t              state;
  logic [DIV_LOG2-1:0] div_cnt;
  logic [7:0]          bit_idx;
  logic                reader_q;
  logic [7:0]          byte_q;
  logic                byte_last_q;
  logic [7:0]          hold_data;
  logic                hold_last;
  logic                hold_full;

  logic       enabled;
  logic       tick;
  logic       accept;
  logic       cur_bit;
  logic [7:0] start_mark;
  logic [15:0] end_mark;
  logic [7:0] end_last;

  assign enabled    = (hi_simulate_mod_type == MODE_READER) || (hi_simulate_mod_type == MODE_TAG);
  assign tick       = &div_cnt;
  // Gated by rst_n so the handshake is also quiet while reset is held.
  assign tx_ready   = rst_n && enabled && !hold_full && (state != S_END) && (state != S_GAP);
  assign accept     = tx_valid && tx_ready;
  assign busy       = (state != S_IDLE);
  assign start_mark = reader_q ? 8'hc0 : 8'hf0;
  assign end_mark   = reader_q ? 16'hc000 : 16'h0000;
  assign end_last   = reader_q ? 8'd15 : 8'd7;

  always_comb begin
    cur_bit = 1'b0;
    case (state)
      S_START: cur_bit = start_mark[~bit_idx[2:0]];
`ifdef RELAY_TX_PARITY_EN
      S_DATA:  cur_bit = bit_idx[3] ? ~^byte_q : byte_q[~bit_idx[2:0]];
`else
      S_DATA:  cur_bit = byte_q[~bit_idx[2:0]];
`endif
      S_END:   cur_bit = end_mark[~bit_idx[3:0]];
      default: cur_bit = 1'b0;
    endcase
  end

  // data_out is the registered copy of cur_bit, so each bit lags its state by one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      div_cnt     <= '0;
      bit_idx     <= '0;
      reader_q    <= 1'b0;
      byte_q      <= '0;
      byte_last_q <= 1'b0;
      hold_data   <= '0;
      hold_last   <= 1'b0;
      hold_full   <= 1'b0;
      data_out    <= 1'b0;
      underrun    <= 1'b0;
      frame_done  <= 1'b0;
    end else if (!enabled) begin
      state      <= S_IDLE;
      div_cnt    <= '0;
      bit_idx    <= '0;
      hold_full  <= 1'b0;
      data_out   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      data_out   <= cur_bit;
      frame_done <= 1'b0;
      div_cnt    <= (state == S_IDLE) ? '0 : div_cnt + DIV_LOG2'(1);
      if (tick && state != S_IDLE) bit_idx <= bit_idx + 8'd1;
      if (accept) begin
        hold_data <= tx_data;
        hold_last <= tx_last;
        hold_full <= 1'b1;
      end
      case (state)
        S_IDLE: if (hold_full) begin
          state    <= S_START;
          bit_idx  <= '0;
          reader_q <= (hi_simulate_mod_type == MODE_READER);
          underrun <= 1'b0;
        end
        S_START: if (tick && bit_idx == 8'd7) begin
          state       <= S_DATA;
          bit_idx     <= '0;
          byte_q      <= hold_data;
          byte_last_q <= hold_last;
          hold_full   <= 1'b0;
        end
        S_DATA: if (tick && bit_idx == BYTE_LAST) begin
          bit_idx <= '0;
          if (byte_last_q) begin
            state <= S_END;
          end else if (hold_full) begin
            byte_q      <= hold_data;
            byte_last_q <= hold_last;
            hold_full   <= 1'b0;
          end else begin
            underrun <= 1'b1;
            state    <= S_END;
          end
        end
        S_END: if (tick && bit_idx == end_last) begin
          state   <= S_GAP;
          bit_idx <= '0;
        end
        S_GAP: if (tick && bit_idx == GAP_LAST) begin
          state      <= S_IDLE;
          bit_idx    <= '0;
          frame_done <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
